// File: rtl/lock_manager_pkg.sv
// ---------------------------------------------------------------------------
// lock_manager_pkg
// Shared definitions for the OmpSs lock manager: command word field
// positions, command and ack codes, the lock table entry type and the
// controller state encoding.
// ---------------------------------------------------------------------------
package lock_manager_pkg;

    // Command word layout (inStream_TDATA)
    localparam int CMD_TYPE_L   = 0;
    localparam int CMD_TYPE_H   = 7;
    localparam int LOCK_ID_BITS = 8;
    localparam int LOCK_ID_L    = 8;
    localparam int LOCK_ID_H    = LOCK_ID_L + LOCK_ID_BITS - 1;

    // Command codes
    localparam logic [7:0] CMD_LOCK_CODE   = 8'h04;
    localparam logic [7:0] CMD_UNLOCK_CODE = 8'h05;

    // Ack codes returned on outStream_TDATA
    localparam logic [7:0] ACK_OK_CODE     = 8'h01;
    localparam logic [7:0] ACK_REJECT_CODE = 8'h02;

    // Widest supported accelerator ID; the table always stores this many
    // owner bits so one entry layout serves every ACC_BITS setting.
    localparam int ACC_BITS = 4;

    typedef struct packed {
        logic                locked;
        logic [ACC_BITS-1:0] owner;
    } lock_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CHECK    = 2'd1,
        ST_SEND_ACK = 2'd2
    } lm_state_t;

    // Range test done on the full index so an out-of-range ID can never
    // alias onto a real entry.
    function automatic logic lock_id_in_range(input logic [LOCK_ID_BITS-1:0] id,
                                              input int num_locks);
        return (32'(id) < 32'(num_locks));
    endfunction

endpackage

// File: rtl/lock_manager_table.sv
// ---------------------------------------------------------------------------
// lock_table
// NUM_LOCKS lock entries held in registers, with a registered read port and a
// single write port. All entries clear asynchronously on rst.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rd_en, rd_addr    read request; rd_data valid the following cycle
//   rd_data           registered entry (all zeros for an out-of-range address)
//   wr_en, wr_addr    write request; out-of-range addresses write nothing
//   wr_data           entry value to store
// ---------------------------------------------------------------------------
module lock_table
    import lock_manager_pkg::*;
#(
    parameter int NUM_LOCKS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_en,
    input  logic [LOCK_ID_BITS-1:0] rd_addr,
    output lock_entry_t             rd_data,
    input  logic                    wr_en,
    input  logic [LOCK_ID_BITS-1:0] wr_addr,
    input  lock_entry_t             wr_data
);

    lock_entry_t          entry_reg [NUM_LOCKS];
    logic [NUM_LOCKS-1:0] wr_hit;
    logic [NUM_LOCKS-1:0] rd_hit;
    lock_entry_t          rd_mux;

    // Full-width address decode per entry: an address at or beyond
    // NUM_LOCKS matches no entry, so it neither reads nor writes anything.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LOCKS; gi++) begin : g_decode
            assign wr_hit[gi] = wr_en && (wr_addr == LOCK_ID_BITS'(gi));
            assign rd_hit[gi] = (rd_addr == LOCK_ID_BITS'(gi));
        end
    endgenerate

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_LOCKS; i++) begin
            if (rd_hit[i]) begin
                rd_mux = entry_reg[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LOCKS; i++) begin
                entry_reg[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            for (int i = 0; i < NUM_LOCKS; i++) begin
                if (wr_hit[i]) begin
                    entry_reg[i] <= wr_data;
                end
            end
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: rtl/lock_manager.sv
// ---------------------------------------------------------------------------
// lock_manager
// Multi-lock arbiter: NUM_LOCKS mutexes, each with an owner accelerator ID,
// serving LOCK/UNLOCK commands one at a time and returning ack codes routed
// back to the requesting accelerator.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   inStream_TDATA      command word (type and lock id fields)
//   inStream_TVALID     command valid
//   inStream_TID        source accelerator (low ACC_BITS used)
//   inStream_TREADY     command accepted (only while idle)
//   outStream_TDATA     ack code
//   outStream_TVALID    ack valid
//   outStream_TREADY    ack sink ready
//   outStream_TDEST     destination accelerator (captured TID)
// ---------------------------------------------------------------------------
module lock_manager
    import lock_manager_pkg::*;
#(
    parameter int NUM_LOCKS  = 16,
    parameter int ACC_BITS   = 4,
    parameter int UNLOCK_ACK = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] inStream_TDATA,
    input  logic        inStream_TVALID,
    input  logic [3:0]  inStream_TID,
    output logic        inStream_TREADY,
    output logic [7:0]  outStream_TDATA,
    output logic        outStream_TVALID,
    input  logic        outStream_TREADY,
    output logic [3:0]  outStream_TDEST
);

    localparam int OWNER_W = $bits(lock_entry_t) - 1;

    lm_state_t               state_reg, state_next;
    logic [7:0]              cmd_reg;
    logic [LOCK_ID_BITS-1:0] id_reg;
    logic [ACC_BITS-1:0]     tid_reg;
    logic [7:0]              ack_data_reg, ack_data_next;
    logic                    in_ready_reg;
    logic                    out_valid_reg;

    logic                    in_fire;
    logic                    in_range;
    logic                    owner_match;
    logic                    ack_due;
    logic [7:0]              ack_code;

    lock_entry_t             rd_entry;
    logic                    tbl_wr_en;
    lock_entry_t             tbl_wr_data;

    // Only the type, id and low TID bits carry meaning.
    logic                    unused_in_bits;
    assign unused_in_bits = ^{inStream_TDATA, inStream_TID};

    // in_ready_reg is only ever high in IDLE, so it doubles as the accept
    // qualifier.
    assign in_fire = inStream_TVALID && in_ready_reg;

    // The table lookup is launched on the accept cycle so the entry is
    // available in CHECK, where it is evaluated and written back.
    lock_table #(
        .NUM_LOCKS (NUM_LOCKS)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (in_fire),
        .rd_addr (inStream_TDATA[LOCK_ID_H:LOCK_ID_L]),
        .rd_data (rd_entry),
        .wr_en   (tbl_wr_en),
        .wr_addr (id_reg),
        .wr_data (tbl_wr_data)
    );

    assign in_range    = lock_id_in_range(id_reg, NUM_LOCKS);
    assign owner_match = (rd_entry.owner == OWNER_W'(tid_reg));

    always_comb begin
        state_next    = state_reg;
        ack_data_next = ack_data_reg;
        tbl_wr_en     = 1'b0;
        tbl_wr_data   = rd_entry;
        ack_due       = 1'b0;
        ack_code      = ACK_REJECT_CODE;

        case (state_reg)
            ST_IDLE: begin
                if (in_fire) begin
                    state_next = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (cmd_reg == CMD_LOCK_CODE) begin
                    ack_due = 1'b1;
                    if (!in_range) begin
                        ack_code = ACK_REJECT_CODE;
                    end else if (!rd_entry.locked) begin
                        tbl_wr_en          = 1'b1;
                        tbl_wr_data.locked = 1'b1;
                        tbl_wr_data.owner  = OWNER_W'(tid_reg);
                        ack_code           = ACK_OK_CODE;
                    end else if (owner_match) begin
                        // Re-locking by the holder succeeds without a change.
                        ack_code = ACK_OK_CODE;
                    end else begin
                        ack_code = ACK_REJECT_CODE;
                    end
                end else if (cmd_reg == CMD_UNLOCK_CODE) begin
                    ack_due = (UNLOCK_ACK != 0);
                    if (in_range && rd_entry.locked && owner_match) begin
                        tbl_wr_en          = 1'b1;
                        tbl_wr_data.locked = 1'b0;
                        ack_code           = ACK_OK_CODE;
                    end
                end
                // Unknown command codes fall through: consumed, no ack.

                if (ack_due) begin
                    state_next    = ST_SEND_ACK;
                    ack_data_next = ack_code;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            ST_SEND_ACK: begin
                if (outStream_TREADY) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Handshake flags are registered from state_next so both drop at once
    // when rst asserts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cmd_reg       <= '0;
            id_reg        <= '0;
            tid_reg       <= '0;
            ack_data_reg  <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ack_data_reg  <= ack_data_next;
            in_ready_reg  <= (state_next == ST_IDLE);
            out_valid_reg <= (state_next == ST_SEND_ACK);
            if (in_fire) begin
                cmd_reg <= inStream_TDATA[CMD_TYPE_H:CMD_TYPE_L];
                id_reg  <= inStream_TDATA[LOCK_ID_H:LOCK_ID_L];
                tid_reg <= inStream_TID[ACC_BITS-1:0];
            end
        end
    end

    assign inStream_TREADY  = in_ready_reg;
    assign outStream_TVALID = out_valid_reg;
    assign outStream_TDATA  = ack_data_reg;
    assign outStream_TDEST  = 4'(tid_reg);

endmodule
